// File: rtl/smul_arbiter_2port_if.sv
// Request/response bundle for the two-port shared signed multiplier.
// The slave modport is the multiplier side; master is the requester/bench side.
interface smul_arbiter_2port_if #(
  parameter int NBITS = 8
);
  logic               req0_val;
  logic               req0_rdy;
  logic [NBITS-1:0]   req0_in0;
  logic [NBITS-1:0]   req0_in1;
  logic               req1_val;
  logic               req1_rdy;
  logic [NBITS-1:0]   req1_in0;
  logic [NBITS-1:0]   req1_in1;
  logic               resp0_val;
  logic               resp0_rdy;
  logic               resp1_val;
  logic               resp1_rdy;
  logic [2*NBITS-1:0] resp_out;
  logic [1:0]         dbg_state;

  modport slave (
    input  req0_val, req0_in0, req0_in1,
    input  req1_val, req1_in0, req1_in1,
    input  resp0_rdy, resp1_rdy,
    output req0_rdy, req1_rdy, resp0_val, resp1_val, resp_out, dbg_state
  );

  modport master (
    output req0_val, req0_in0, req0_in1,
    output req1_val, req1_in0, req1_in1,
    output resp0_rdy, resp1_rdy,
    input  req0_rdy, req1_rdy, resp0_val, resp1_val, resp_out, dbg_state
  );
endinterface

// File: rtl/smul_arbiter_2port.sv
// Two requesters share one NBITS-cycle shift-add signed multiplier, round-robin arbitrated.
// Optional SMUL_ARB_ZERO_BYPASS_EN: a zero operand skips BUSY and answers 0 directly.
//
// Handshake: a transfer happens on a rising edge where val and rdy are both 1.
// val/data are held stable by the sender until that edge; rdy never depends on
// anything but state, the val inputs and the priority pointer.
module smul_arbiter_2port #(
  parameter int NBITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  smul_arbiter_2port_if.slave   io_bus
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int PW = 2 * NBITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_prio;
  logic            r_owner;
  logic [PW-1:0]   r_mcand;
  logic [NBITS-1:0] r_mplier;
  logic [PW-1:0]   r_prod;
  logic [CW-1:0]   r_cnt;

  logic            w_grant0;
  logic            w_grant1;
  logic            w_sel;
  logic [NBITS-1:0] w_a;
  logic [NBITS-1:0] w_b;
  logic            w_req_fire;
  logic            w_resp_fire;
  logic            w_last;
  logic            w_req0_rdy;
  logic            w_req1_rdy;
  logic            w_resp0_val;
  logic            w_resp1_val;
  logic [PW-1:0]   w_resp_out;

  // Tie goes to the port named by r_prio; a lone valid port always wins.
  assign w_grant0 = io_bus.req0_val & (~io_bus.req1_val | ~r_prio);
  assign w_grant1 = io_bus.req1_val & (~io_bus.req0_val |  r_prio);
  assign w_sel    = w_grant1;
  assign w_a      = w_sel ? io_bus.req1_in0 : io_bus.req0_in0;
  assign w_b      = w_sel ? io_bus.req1_in1 : io_bus.req0_in1;

  // reset gates rdy so the outputs drop the instant reset asserts, not at an edge.
  assign w_req_fire  = (r_state == S_IDLE) & reset & (w_grant0 | w_grant1);
  assign w_resp_fire = (r_state == S_DONE) & (r_owner ? io_bus.resp1_rdy : io_bus.resp0_rdy);
  assign w_last      = (r_cnt == CW'(NBITS - 1));

`ifdef SMUL_ARB_ZERO_BYPASS_EN
  logic w_zero;
  assign w_zero = (w_a == '0) | (w_b == '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req0_rdy  = 1'b0;
    w_req1_rdy  = 1'b0;
    w_resp0_val = 1'b0;
    w_resp1_val = 1'b0;
    w_resp_out  = '0;
    unique case (r_state)
      S_IDLE: begin
        w_req0_rdy = w_grant0 & reset;
        w_req1_rdy = w_grant1 & reset;
`ifdef SMUL_ARB_ZERO_BYPASS_EN
        if (w_req_fire) w_state_nxt = w_zero ? S_DONE : S_BUSY;
`else
        if (w_req_fire) w_state_nxt = S_BUSY;
`endif
      end
      S_BUSY: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_resp0_val = ~r_owner;
        w_resp1_val =  r_owner;
        w_resp_out  = r_prod;
        if (w_resp_fire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplier MSB carries weight -2^(NBITS-1), so the final step subtracts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_req_fire) begin
        r_owner  <= w_sel;
        r_mcand  <= {{NBITS{w_a[NBITS-1]}}, w_a};
        r_mplier <= w_b;
        r_prod   <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_BUSY) begin
        if (r_mplier[0]) begin
          r_prod <= w_last ? (r_prod - r_mcand) : (r_prod + r_mcand);
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end
      if (w_resp_fire) begin
        r_prio <= ~r_owner;
      end
    end
  end

  assign io_bus.req0_rdy  = w_req0_rdy;
  assign io_bus.req1_rdy  = w_req1_rdy;
  assign io_bus.resp0_val = w_resp0_val;
  assign io_bus.resp1_val = w_resp1_val;
  assign io_bus.resp_out  = w_resp_out;
  assign io_bus.dbg_state = r_state;

endmodule

// File: tb/tb_smul_arbiter_2port.sv
// Bench for smul_arbiter_2port: vector table, hand-written corner sequences and a
// response scoreboard fed at request fire and drained at response fire.
module tb_smul_arbiter_2port;
  localparam int NB  = 8;
  localparam int W   = 2 * NB;
  localparam int LAT = NB + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  smul_arbiter_2port_if #(.NBITS(NB)) bus ();

  smul_arbiter_2port #(.NBITS(NB)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  typedef struct {
    bit            port;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [W-1:0]  exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [W:0]  exp_q[$];
  bit          last_owner = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = {{NB{a[NB-1]}}, a};
    sb = {{NB{b[NB-1]}}, b};
    return sa * sb;
  endfunction

  function automatic int exp_lat(input logic [NB-1:0] a, input logic [NB-1:0] b);
`ifdef SMUL_ARB_ZERO_BYPASS_EN
    if (a == '0 || b == '0) return 1;
`endif
    return LAT;
  endfunction

  // Drive a request until it fires; returns at the negedge of cycle 1 with val dropped.
  task automatic send(input bit p, input logic [NB-1:0] a, input logic [NB-1:0] b,
                      input logic [W-1:0] exp);
    int t = 0;
    @(negedge clk);
    if (p) begin bus.req1_val = 1'b1; bus.req1_in0 = a; bus.req1_in1 = b; end
    else   begin bus.req0_val = 1'b1; bus.req0_in0 = a; bus.req0_in1 = b; end
    #1;
    while (!(p ? bus.req1_rdy : bus.req0_rdy) && t < 40) begin
      @(negedge clk); #1; t++;
    end
    if (!(p ? bus.req1_rdy : bus.req0_rdy)) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: port %0d rdy still 0 after %0d cycles, expected 1", p, t);
    end else begin
      exp_q.push_back({p, exp});
    end
    @(negedge clk);
    if (p) bus.req1_val = 1'b0; else bus.req0_val = 1'b0;
  endtask

  // Called at the negedge of cycle 1; returns the cycle index where resp_val is seen.
  task automatic wait_resp(input bit p, output int cyc);
    cyc = 1;
    #1;
    while (!(p ? bus.resp1_val : bus.resp0_val) && cyc < 40) begin
      @(negedge clk); #1; cyc++;
    end
    if (!(p ? bus.resp1_val : bus.resp0_val)) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: port %0d resp_val 0 after %0d cycles, expected 1", p, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard drain: sampled just before each rising edge.
  initial begin
    logic [W:0] e;
    bit         p;
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        last_owner = 1'b1;
      end else begin
        if (bus.resp0_val && bus.resp1_val) check("resp_val_onehot", 2'b11, 2'b01);
        if ((bus.resp0_val && bus.resp0_rdy) || (bus.resp1_val && bus.resp1_rdy)) begin
          p = bus.resp1_val;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL resp_unexpected: port %0d out %h, expected no response", p, bus.resp_out);
          end else begin
            e = exp_q.pop_front();
            check("resp_port_data", {p, bus.resp_out}, e);
          end
          last_owner = p;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    int   c, g, cyc;
    bit   p, exp_g, ref0, ref1;

    vecs[0] = '{1'b0, 8'h03, 8'hfc, 16'hfff4};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[2] = '{1'b0, 8'h7f, 8'hff, 16'hff81};
    vecs[3] = '{1'b1, 8'hf4, 8'hf3, 16'h009c};
    vecs[4] = '{1'b0, 8'hd6, 8'h5a, 16'hf13c};
    vecs[5] = '{1'b1, 8'h7f, 8'h7f, 16'h3f01};
    vecs[6] = '{1'b0, 8'h80, 8'h7f, 16'hc080};
    vecs[7] = '{1'b0, 8'h00, 8'hff, 16'h0000};
    vecs[8] = '{1'b1, 8'hff, 8'hff, 16'h0001};
    vecs[9] = '{1'b1, 8'h01, 8'h80, 16'hff80};

    bus.req0_val = 1'b1; bus.req0_in0 = 8'h11; bus.req0_in1 = 8'h22;
    bus.req1_val = 1'b1; bus.req1_in0 = 8'h33; bus.req1_in1 = 8'h44;
    bus.resp0_rdy = 1'b1; bus.resp1_rdy = 1'b1;

    // Reset state with both requesters asking.
    #3;
    check("rst_req0_rdy", bus.req0_rdy, 0);
    check("rst_req1_rdy", bus.req1_rdy, 0);
    check("rst_resp0_val", bus.resp0_val, 0);
    check("rst_resp1_val", bus.resp1_val, 0);
    check("rst_resp_out", bus.resp_out, 0);
    repeat (2) @(negedge clk);
    bus.req0_val = 1'b0; bus.req1_val = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_state_idle", bus.dbg_state, 0);

    // Single request: exact response cycle, no rdy while occupied.
    send(1'b0, 8'h03, 8'hfc, 16'hfff4);
    bus.req1_val = 1'b1; bus.req1_in0 = 8'h05; bus.req1_in1 = 8'h05;
    for (int k = 1; k <= LAT; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      check("busy_req1_rdy", bus.req1_rdy, 0);
      check("single_resp0_val", bus.resp0_val, (k == LAT));
    end
    bus.req1_val = 1'b0;

    // Table vectors.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_resp(vecs[i].port, c);
      check("vec_latency", c, exp_lat(vecs[i].a, vecs[i].b));
    end

    // Simultaneous requests right after reset: prio starts at port 0.
    do_reset();
    bus.req0_val = 1'b1; bus.req0_in0 = 8'h80; bus.req0_in1 = 8'h80;
    bus.req1_val = 1'b1; bus.req1_in0 = 8'h7f; bus.req1_in1 = 8'hff;
    #1;
    check("sim_req0_rdy", bus.req0_rdy, 1);
    check("sim_req1_rdy", bus.req1_rdy, 0);
    exp_q.push_back({1'b0, 16'h4000});
    @(negedge clk);
    bus.req0_val = 1'b0;
    wait_resp(1'b0, c);
    check("sim_lat0", c, LAT);
    check("sim_req1_rdy_done", bus.req1_rdy, 0);
    @(negedge clk); #1;
    check("sim_req1_rdy_after", bus.req1_rdy, 1);
    exp_q.push_back({1'b1, 16'hff81});
    @(negedge clk);
    bus.req1_val = 1'b0;
    wait_resp(1'b1, c);
    check("sim_lat1", c, LAT);

    // Fairness: both ports hold val for four grants.
    bus.req0_in0 = 8'($urandom_range(0, 255)); bus.req0_in1 = 8'($urandom_range(0, 255));
    bus.req1_in0 = 8'($urandom_range(0, 255)); bus.req1_in1 = 8'($urandom_range(0, 255));
    @(negedge clk);
    bus.req0_val = 1'b1; bus.req1_val = 1'b1;
    g = 0; cyc = 0; exp_g = ~last_owner; ref0 = 1'b0; ref1 = 1'b0;
    while (g < 4 && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      if (ref0) begin bus.req0_in0 = 8'($urandom_range(0, 255)); bus.req0_in1 = 8'($urandom_range(0, 255)); end
      if (ref1) begin bus.req1_in0 = 8'($urandom_range(0, 255)); bus.req1_in1 = 8'($urandom_range(0, 255)); end
      ref0 = 1'b0; ref1 = 1'b0;
      #1; cyc++;
      if (bus.req0_rdy || bus.req1_rdy) begin
        check("fair_onehot", {bus.req0_rdy, bus.req1_rdy} == 2'b11, 0);
        p = bus.req1_rdy;
        check("fair_grant", p, exp_g);
        exp_q.push_back({p, p ? model(bus.req1_in0, bus.req1_in1) : model(bus.req0_in0, bus.req0_in1)});
        exp_g = ~p;
        if (p) ref1 = 1'b1; else ref0 = 1'b1;
        g++;
      end
    end
    if (g < 4) check("fair_grant_count", g, 4);
    @(negedge clk);
    bus.req0_val = 1'b0; bus.req1_val = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin @(negedge clk); cyc++; end
    check("fair_drained", exp_q.size(), 0);

    // Backpressure on port 1 while port 0 keeps asking.
    bus.resp1_rdy = 1'b0;
    send(1'b1, 8'hf4, 8'hf3, 16'h009c);
    wait_resp(1'b1, c);
    check("bp_lat", c, LAT);
    bus.req0_val = 1'b1; bus.req0_in0 = 8'h02; bus.req0_in1 = 8'h03;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("bp_resp1_val", bus.resp1_val, 1);
      check("bp_resp_out", bus.resp_out, 16'h009c);
      check("bp_req0_rdy", bus.req0_rdy, 0);
      check("bp_resp0_val", bus.resp0_val, 0);
    end
    @(negedge clk);
    bus.req0_val = 1'b0; bus.resp1_rdy = 1'b1;
    @(negedge clk); #1;
    check("bp_released", bus.resp1_val, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of BUSY drops the transaction.
    send(1'b0, 8'h05, 8'h07, 16'd35);
    repeat (3) @(negedge clk);
    #2;
    check("mid_busy_state", bus.dbg_state, 1);
    bus.req0_val = 1'b1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_req0_rdy", bus.req0_rdy, 0);
    check("mid_rst_resp0_val", bus.resp0_val, 0);
    check("mid_rst_resp_out", bus.resp_out, 0);
    check("mid_rst_state", bus.dbg_state, 0);
    @(negedge clk);
    bus.req0_val = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    send(1'b1, 8'hd6, 8'h5a, 16'hf13c);
    wait_resp(1'b1, c);
    check("post_rst_lat", c, LAT);

    // Random operands on alternating ports.
    for (int i = 0; i < 20; i++) begin
      logic [NB-1:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(i[0], ra, rb, model(ra, rb));
      wait_resp(i[0], c);
      check("rand_latency", c, exp_lat(ra, rb));
    end

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
